// File: rtl/arithm_pkg.sv
// Small arithmetic helpers shared across the codebase.
package arithm_pkg;

  // Smallest r with 2**r >= n.
  function automatic int log2ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_pkg.sv
// FIFO helpers: width of the fifo level type and the threshold-check functions.
package fifo_pkg;

  // Width of a fifo_level_t able to hold every count from 0 to depth inclusive.
  function automatic int fifo_level_t_width(input int depth);
    return arithm_pkg::log2ceil(depth) + 1;
  endfunction

  function automatic logic at_or_above(input int lvl, input int th);
    return lvl >= th;
  endfunction

  function automatic logic at_or_below(input int lvl, input int th);
    return lvl <= th;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with synchronous reset, clear and increment; wraps MAX-1 -> 0.
module wrap_counter #(
  parameter int MAX = 8,
  localparam int W = arithm_pkg::log2ceil(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= (cnt_q == W'(MAX - 1)) ? '0 : cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level and threshold flags.
// Optional sticky overflow/underflow flags when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 1,
  localparam int ADDR_WIDTH = arithm_pkg::log2ceil(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_o,
  output logic                  udf_o
`endif
);

  localparam int LEVEL_W = fifo_level_t_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LEVEL_W-1:0]    level_q;
  logic                  push;
  logic                  pop;

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and ready/valid here come only from level_q.
  assign wr_ready_o = level_q < LEVEL_W'(DEPTH);
  assign rd_valid_o = level_q != '0;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;

  wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push),
    .cnt_o (wr_ptr)
  );

  wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop),
    .cnt_o (rd_ptr)
  );

  // Storage is never cleared; a flushed or reset FIFO simply ignores stale words.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_q <= level_q - LEVEL_W'(1);
    end
  end

  assign rd_data_o      = mem[rd_ptr];
  assign level_o        = level_q;
  assign almost_full_o  = at_or_above(int'(level_q), AFULL_TH);
  assign almost_empty_o = at_or_below(int'(level_q), AEMPTY_TH);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_valid_i && !wr_ready_o) ovf_q <= 1'b1;
      if (rd_ready_i && !rd_valid_o) udf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=5): directed scenarios plus random traffic
// against a queue-based reference model.
module tb_sync_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 5;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [3:0]   level;
  logic         almost_full;
  logic         almost_empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic         ovf;
  logic         udf;
`endif

  // clock / reset
  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_ready_o     (wr_ready),
    .rd_ready_i     (rd_ready),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .level_o        (level),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .ovf_o          (ovf),
    .udf_o          (udf)
`endif
  );

  // scoreboard: FIFO contents as a plain queue, plus sticky flags
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         exp_udf;
  int           n_cmp;
  int           n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("wr_ready", wr_ready, sz < DEPTH);
    check("rd_valid", rd_valid, sz != 0);
    check("level", level, sz);
    check("almost_full", almost_full, sz >= AF_TH);
    check("almost_empty", almost_empty, sz <= AE_TH);
    if (sz != 0) check("rd_data", rd_data, exp_q[0]);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("ovf", ovf, exp_ovf);
    check("udf", udf, exp_udf);
`endif
  endtask

  // driver: one clock cycle of stimulus, check before the edge, update model at the edge
  task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic rr,
                       input logic fl, input logic rs);
    int sz;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    sz = exp_q.size();
    if (rs || fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (wv && sz >= DEPTH) exp_ovf = 1'b1;
      if (rr && sz == 0)     exp_udf = 1'b1;
      if (rr && sz != 0)     void'(exp_q.pop_front());
      if (wv && sz < DEPTH)  exp_q.push_back(wd);
    end
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("reset_wr_ready", wr_ready, 1);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_level", level, 0);
    check("reset_aempty", almost_empty, 1);
    check("reset_afull", almost_full, 0);

    // fill to full with 0xA0..0xA4
    for (int i = 0; i < DEPTH; i++) push(32'hA0 + i);
    check("full_wr_ready", wr_ready, 0);
    check("full_level", level, 5);
    check("full_afull", almost_full, 1);
    check("full_head", rd_data, 32'hA0);

    // drain, then push/pop rounds carrying the pointers across 4 -> 0
    for (int i = 0; i < DEPTH; i++) pop();
    for (int i = 0; i < 7; i++) begin
      push(32'hB0 + i);
      check("wrap_data", rd_data, 32'hB0 + i);
      pop();
    end
    check("wrap_empty_level", level, 0);

    // full FIFO, write and read offered together: only the pop happens
    for (int i = 0; i < DEPTH; i++) push(32'hC0 + i);
    cycle(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    check("full_both_level", level, 4);
    check("full_both_head", rd_data, 32'hC1);
    for (int i = 0; i < 4; i++) pop();
    check("full_both_drained", rd_valid, 0);

    // flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) push(32'hD0 + i);
    check("pre_flush_level", level, 3);
    cycle(1'b1, 32'hDD, 1'b1, 1'b1, 1'b0);
    check("flush_level", level, 0);
    check("flush_rd_valid", rd_valid, 0);

    // reset mid-operation
    push(32'hE0);
    push(32'hE1);
    check("pre_rst_level", level, 2);
    cycle(1'b1, 32'hEE, 1'b1, 1'b0, 1'b1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_afull", almost_full, 0);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // underflow is sticky until flush
    pop();
    check("udf_set", udf, 1);
    repeat (3) push(32'hF0);
    pop();
    check("udf_held", udf, 1);
    check("ovf_clear", ovf, 0);
    repeat (3) push(32'hF1);
    push(32'hF2);
    check("ovf_set", ovf, 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("udf_flushed", udf, 0);
    check("ovf_flushed", ovf, 0);
`endif

    // random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0));
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
